// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB master port among NUM_REQ requesters.
// It runs the SETUP/ACCESS sequence for the winner and aborts the transfer if the slave stalls too long.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr_i,
  input  logic [NUM_REQ-1:0]        req_write_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata_i,
  output logic [NUM_REQ-1:0]        gnt_o,
  output logic [NUM_REQ-1:0]        done_o,
  output logic [DATA_W-1:0]         rdata_o,
  output logic                      err_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic                      pwrite_o,
  output logic [ADDR_W-1:0]         paddr_o,
  output logic [DATA_W-1:0]         pwdata_o,
  input  logic [DATA_W-1:0]         prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_inc;
  logic [ADDR_W-1:0]    paddr_q, paddr_d;
  logic                 pwrite_q, pwrite_d;
  logic [DATA_W-1:0]    pwdata_q, pwdata_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic [IDX_W:0]       pick;
  logic [IDX_W-1:0]     win;
  logic                 found;

  // Returns {found, index} of the first requester strictly after 'last', wrapping.
  function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                             input logic [IDX_W-1:0]   last);
    logic [IDX_W:0] res;
    int             idx;
    res = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!res[IDX_W] && req[IDX_W'(idx)]) res = {1'b1, IDX_W'(idx)};
    end
    return res;
  endfunction

  assign pick    = rr_pick(req_i, last_q);
  assign win     = pick[IDX_W-1:0];
  assign found   = pick[IDX_W];
  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    done_d   = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          paddr_d  = req_addr_i[int'(win)*ADDR_W +: ADDR_W];
          pwdata_d = req_wdata_i[int'(win)*DATA_W +: DATA_W];
          pwrite_d = req_write_i[win];
          owner_d  = win;
          last_d   = win;
          cnt_d    = '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        state_d = ACCESS;
      end
      ACCESS: begin
        if (pready_i) begin
          rdata_d         = prdata_i;
          err_d           = pslverr_i;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (TIMEOUT != 0 && cnt_inc == TO_CNT) begin
          // Abort fires at equality, so the counter never wraps.
          rdata_d         = '0;
          err_d           = 1'b1;
          done_d[owner_q] = 1'b1;
          state_d         = IDLE;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      last_q   <= IDX_W'(NUM_REQ - 1);
      owner_q  <= '0;
      cnt_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Grant is combinational in IDLE; held off while reset is asserted so outputs read 0.
  assign gnt_o     = (state_q == IDLE && found && !reset) ? (NUM_REQ'(1) << win) : '0;
  assign done_o    = done_q;
  assign rdata_o   = rdata_q;
  assign err_o     = err_q;
  assign psel_o    = (state_q != IDLE);
  assign penable_o = (state_q == ACCESS);
  assign pwrite_o  = pwrite_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: read, write with wait states, slave error,
// round-robin order, timeout abort and asynchronous reset during ACCESS.
module tb_apb_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;

  logic                      clk = 1'b0;
  logic                      reset = 1'b0;
  logic [NUM_REQ-1:0]        req_i = '0;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i = '0;
  logic [NUM_REQ-1:0]        req_write_i = '0;
  logic [NUM_REQ*DATA_W-1:0] req_wdata_i = '0;
  logic [NUM_REQ-1:0]        gnt_o, done_o;
  logic [DATA_W-1:0]         rdata_o;
  logic                      err_o, psel_o, penable_o, pwrite_o;
  logic [ADDR_W-1:0]         paddr_o;
  logic [DATA_W-1:0]         pwdata_o;
  logic [DATA_W-1:0]         prdata_i = '0;
  logic                      pready_i = 1'b0;
  logic                      pslverr_i = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  apb_rr_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_i(req_i), .req_addr_i(req_addr_i), .req_write_i(req_write_i), .req_wdata_i(req_wdata_i),
    .gnt_o(gnt_o), .done_o(done_o), .rdata_o(rdata_o), .err_o(err_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o),
    .prdata_i(prdata_i), .pready_i(pready_i), .pslverr_i(pslverr_i)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #2;
  endtask

  task automatic set_cmd(input int i, input logic [31:0] a, input logic w, input logic [31:0] d);
    req_addr_i[i*ADDR_W +: ADDR_W] = a;
    req_write_i[i]                 = w;
    req_wdata_i[i*DATA_W +: DATA_W] = d;
  endtask

  initial begin
    logic [31:0] eg;
    // Reset state, with requests already pending
    req_i = 4'b1111;
    #1 reset = 1'b1;
    #1;
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_psel", 32'(psel_o), 32'h0);
    chk("rst_done", 32'(done_o), 32'h0);
    chk("rst_paddr", paddr_o, 32'h0);
    next_cycle;
    next_cycle;
    reset = 1'b0;
    req_i = '0;

    // Single read by requester 2
    next_cycle;
    set_cmd(2, 32'h0000_1000, 1'b0, 32'h0);
    req_i = 4'b0100;
    #1;
    chk("t1_gnt", 32'(gnt_o), 32'h4);
    chk("t1_psel_idle", 32'(psel_o), 32'h0);
    next_cycle;
    req_i = '0;
    pready_i = 1'b1;
    prdata_i = 32'hFFFF_FFFF;
    #1;
    chk("t1_gnt_off", 32'(gnt_o), 32'h0);
    chk("t1_setup_psel", 32'(psel_o), 32'h1);
    chk("t1_setup_pen", 32'(penable_o), 32'h0);
    chk("t1_paddr", paddr_o, 32'h0000_1000);
    chk("t1_pwrite", 32'(pwrite_o), 32'h0);
    next_cycle;
    prdata_i = 32'hA5A5_0001;
    #1;
    chk("t1_acc_psel", 32'(psel_o), 32'h1);
    chk("t1_acc_pen", 32'(penable_o), 32'h1);
    chk("t1_acc_done", 32'(done_o), 32'h0);
    next_cycle;
    pready_i = 1'b0;
    #1;
    chk("t1_done", 32'(done_o), 32'h4);
    chk("t1_rdata", rdata_o, 32'hA5A5_0001);
    chk("t1_err", 32'(err_o), 32'h0);
    chk("t1_psel_end", 32'(psel_o), 32'h0);

    // Write with three wait states by requester 1
    next_cycle;
    set_cmd(1, 32'h0000_0040, 1'b1, 32'h1234_5678);
    req_i = 4'b0010;
    #1;
    chk("t3_gnt", 32'(gnt_o), 32'h2);
    for (int w = 1; w <= 5; w++) begin
      next_cycle;
      if (w == 1) begin
        req_i = '0;
        set_cmd(1, 32'hFFFF_FFF0, 1'b0, 32'h0);
      end
      pready_i = (w == 5);
      prdata_i = 32'hDEAD_0000;
      #1;
      chk("t3_paddr", paddr_o, 32'h0000_0040);
      chk("t3_pwdata", pwdata_o, 32'h1234_5678);
      chk("t3_pwrite", 32'(pwrite_o), 32'h1);
      chk("t3_pen", 32'(penable_o), (w >= 2) ? 32'h1 : 32'h0);
      chk("t3_done_wait", 32'(done_o), 32'h0);
    end
    next_cycle;
    pready_i = 1'b0;
    #1;
    chk("t3_done", 32'(done_o), 32'h2);
    chk("t3_rdata", rdata_o, 32'hDEAD_0000);
    chk("t3_err", 32'(err_o), 32'h0);

    // Slave error, then a clean transfer granted in the completion cycle
    next_cycle;
    set_cmd(0, 32'h0000_0080, 1'b0, 32'h0);
    req_i = 4'b0001;
    #1;
    chk("t4_gnt", 32'(gnt_o), 32'h1);
    next_cycle;
    req_i = '0;
    pslverr_i = 1'b1;
    next_cycle;
    pready_i = 1'b1;
    prdata_i = 32'h1111_2222;
    next_cycle;
    pready_i = 1'b0;
    pslverr_i = 1'b0;
    set_cmd(3, 32'h0000_00C0, 1'b0, 32'h0);
    req_i = 4'b1000;
    #1;
    chk("t4_done", 32'(done_o), 32'h1);
    chk("t4_err", 32'(err_o), 32'h1);
    chk("t4_rdata", rdata_o, 32'h1111_2222);
    chk("t4_gnt_next", 32'(gnt_o), 32'h8);
    next_cycle;
    req_i = '0;
    #1;
    chk("t4_err_hold", 32'(err_o), 32'h1);
    next_cycle;
    pready_i = 1'b1;
    prdata_i = 32'h3333_4444;
    next_cycle;
    pready_i = 1'b0;
    #1;
    chk("t4_done2", 32'(done_o), 32'h8);
    chk("t4_err_clr", 32'(err_o), 32'h0);
    chk("t4_rdata2", rdata_o, 32'h3333_4444);

    // Round-robin: all four hold requests, zero-wait slave
    for (int i = 0; i < NUM_REQ; i++) set_cmd(i, 32'h100 * (i + 1), 1'b0, 32'h0);
    for (int c = 0; c < 24; c++) begin
      next_cycle;
      if (c == 0) begin
        req_i = 4'b1111;
        pready_i = 1'b1;
      end
      prdata_i = 32'hC0DE_0000 + 32'(c);
      #1;
      eg = (c % 3 == 0) ? (32'h1 << ((c / 3) % 4)) : 32'h0;
      chk("rr_gnt", 32'(gnt_o), eg);
      if (c % 3 == 1) chk("rr_paddr", paddr_o, 32'h100 * (((c / 3) % 4) + 1));
      if (c >= 3 && c % 3 == 0) begin
        chk("rr_done", 32'(done_o), 32'h1 << ((c / 3 - 1) % 4));
        chk("rr_rdata", rdata_o, 32'hC0DE_0000 + 32'(c - 1));
      end else begin
        chk("rr_done_idle", 32'(done_o), 32'h0);
      end
    end
    next_cycle;
    req_i = '0;
    #1;
    chk("rr_gnt_end", 32'(gnt_o), 32'h0);
    chk("rr_done_end", 32'(done_o), 32'h8);
    pready_i = 1'b0;

    // Timeout with pready held low
    next_cycle;
    set_cmd(2, 32'h0000_0200, 1'b0, 32'h0);
    req_i = 4'b0100;
    #1;
    chk("to_gnt", 32'(gnt_o), 32'h4);
    for (int c = 1; c <= 17; c++) begin
      next_cycle;
      if (c == 1) req_i = '0;
      prdata_i = 32'h7777_7777;
      #1;
      chk("to_done_wait", 32'(done_o), 32'h0);
      chk("to_psel", 32'(psel_o), 32'h1);
      chk("to_pen", 32'(penable_o), (c >= 2) ? 32'h1 : 32'h0);
    end
    next_cycle;
    set_cmd(0, 32'h0000_0300, 1'b0, 32'h0);
    req_i = 4'b0001;
    #1;
    chk("to_done", 32'(done_o), 32'h4);
    chk("to_err", 32'(err_o), 32'h1);
    chk("to_rdata", rdata_o, 32'h0);
    chk("to_psel_drop", 32'(psel_o), 32'h0);
    chk("to_gnt_next", 32'(gnt_o), 32'h1);
    next_cycle;
    req_i = '0;
    next_cycle;
    pready_i = 1'b1;
    prdata_i = 32'h0000_0055;
    next_cycle;
    pready_i = 1'b0;
    #1;
    chk("to_done2", 32'(done_o), 32'h1);
    chk("to_err2", 32'(err_o), 32'h0);
    chk("to_rdata2", rdata_o, 32'h0000_0055);

    // Asynchronous reset during ACCESS
    next_cycle;
    set_cmd(1, 32'h0000_0400, 1'b1, 32'h0000_AAAA);
    req_i = 4'b0010;
    #1;
    chk("rs_gnt", 32'(gnt_o), 32'h2);
    next_cycle;
    req_i = '0;
    next_cycle;
    #1;
    chk("rs_pen_pre", 32'(penable_o), 32'h1);
    #1;
    reset = 1'b1;
    req_i = 4'b1001;
    #1;
    chk("rs_psel", 32'(psel_o), 32'h0);
    chk("rs_pen", 32'(penable_o), 32'h0);
    chk("rs_paddr", paddr_o, 32'h0);
    chk("rs_pwdata", pwdata_o, 32'h0);
    chk("rs_pwrite", 32'(pwrite_o), 32'h0);
    chk("rs_gnt_off", 32'(gnt_o), 32'h0);
    chk("rs_done", 32'(done_o), 32'h0);
    chk("rs_rdata", rdata_o, 32'h0);
    chk("rs_err", 32'(err_o), 32'h0);
    next_cycle;
    #1;
    chk("rs_done_hold", 32'(done_o), 32'h0);
    next_cycle;
    reset = 1'b0;
    #1;
    chk("rs_gnt_after", 32'(gnt_o), 32'h1);
    next_cycle;
    req_i = '0;
    #1;
    chk("rs_paddr_new", paddr_o, 32'h0000_0300);
    chk("rs_done_setup", 32'(done_o), 32'h0);
    next_cycle;
    pready_i = 1'b1;
    prdata_i = 32'h0000_0066;
    #1;
    chk("rs_done_acc", 32'(done_o), 32'h0);
    next_cycle;
    pready_i = 1'b0;
    #1;
    chk("rs_done_new", 32'(done_o), 32'h1);
    chk("rs_rdata_new", rdata_o, 32'h0000_0066);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
